miso_tx_arbiter: RTL and testbench
==================================

# miso_tx_arbiter

Transmit scheduler for the SPI slave MISO path. It shares one MISO shift-out register among NUM_REQ byte requesters using round-robin arbitration. While chip-select is active it sequences the load and shift controls of that register, one DATA_WIDTH-bit byte every DATA_WIDTH clocks. When no requester has data, it sends an idle byte and flags an underrun.

## Interface
- DATA_WIDTH, 8: bits per transmitted byte; ≥2.
- NUM_REQ, 4: number of requesters; ≥2.
- IDLE_BYTE, 8'hFF: value loaded when no requester is valid at a byte boundary.
- clk  in  1  SPI bit clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cs_n  in  1  chip select, active low; already synchronous to clk.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs on req_valid[i] & req_ready[i].
- sh_load  out  1  one-cycle load strobe to the shift register.
- sh_data  out  DATA_WIDTH  byte to load; valid when sh_load=1.
- sh_shift  out  1  shift enable to the shift register.
- grant_id  out  clog2(NUM_REQ)  index of the requester owning the current byte; holds its value between grants.
- busy  out  1  high when state ≠ IDLE.
- underrun  out  1  one-cycle pulse when IDLE_BYTE is loaded.
- abort  out  1  one-cycle pulse when cs_n rises mid-byte.

## Operation
- States: IDLE, ARB, SHIFT. Registered state: bit_cnt (clog2(DATA_WIDTH) bits), last_grant pointer, grant_id.
- IDLE
  - All strobes are 0.
  - cs_n sampled low → ARB on the next cycle.
- ARB (exactly one cycle)
  - Winner is the first valid index searched from last_grant+1 upward, wrapping modulo NUM_REQ.
  - If a winner w exists: req_ready[w]=1 (combinational from req_valid in ARB), sh_load=1, sh_data=req_data[w], grant_id←w, last_grant←w.
  - If no requester is valid: sh_load=1, sh_data=IDLE_BYTE, underrun=1. grant_id and last_grant are unchanged.
  - Next state SHIFT; bit_cnt←0.
- SHIFT
  - sh_shift=1 every cycle; bit_cnt increments.
  - When bit_cnt = DATA_WIDTH-2 → ARB next cycle.
  - Result: DATA_WIDTH-1 shifts per byte, so the byte period is DATA_WIDTH cycles with no gap between bytes.
- cs_n high
  - In ARB or SHIFT, cs_n sampled high → IDLE next cycle, and strobes are 0 in that cycle.
  - If the state was SHIFT, or was ARB having just loaded, abort=1 for that cycle. The accepted byte is dropped, not retried.
- last_grant persists across cs_n deassertion; it is reset only by rst.
- Requester protocol: hold req_data stable while req_valid=1 until accepted. Dropping req_valid before acceptance is legal.
- sh_data is don't-care when sh_load=0 and is driven to 0.

## Timing
- Reset values: state IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), grant_id=0, bit_cnt=0. All outputs 0.
- Asynchronous reset mid-byte returns to IDLE immediately. No abort pulse is generated.
- Latency from cs_n low (sampled) to the first sh_load: 1 cycle.
- req_valid→req_ready: combinational within ARB only. req_ready is never asserted outside ARB.
- Simultaneous events
  - A requester deasserting valid in the ARB cycle is not granted.
  - cs_n rising in the ARB cycle: the load still occurs, then IDLE follows with abort=1.
- Pointer wrap: when last_grant=NUM_REQ-1, the search starts at index 0.

## Test plan
- Reset, cs_n=0, req_valid=4'b0001, req0 data=8'hA5 → sh_load at cycle 1 with sh_data=A5, req_ready=0001, grant_id=0. Then 7 cycles of sh_shift, then the next ARB at cycle 9.
- All four requesters valid with data 11/22/33/44 over 5 bytes → grant order 0,1,2,3,0. Each sh_load is spaced exactly 8 cycles apart.
- cs_n=0 with req_valid=0 → sh_data=FF and underrun=1 at every ARB. grant_id and the pointer stay unchanged.
- cs_n rises after 3 shifts of byte 8'h3C → abort pulse and return to IDLE. On re-select with only req1 valid, req1 is granted (pointer retained, req0 not re-granted).
- Only req3 valid after a grant of 3 → req3 is granted again via wrap. Then req2 and req3 are both valid → req2 is granted (search starts at index 0).
- Assert rst low during SHIFT → all outputs 0 immediately. After release, the first grant goes to req0.

Source files
------------

// File: rtl/miso_tx_arbiter.sv
// Round-robin transmit scheduler feeding the SPI slave MISO shift register.
// Issues one load per DATA_WIDTH-cycle byte period while chip-select is active.
module miso_tx_arbiter #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           NUM_REQ    = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          sh_load,
  output logic [DATA_WIDTH-1:0]         sh_data,
  output logic                          sh_shift,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          underrun,
  output logic                          abort
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SHIFT
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         bit_cnt;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         win;
  logic [GW-1:0]         cand;
  logic                  found;
  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    sh_load    = 1'b0;
    sh_data    = '0;
    sh_shift   = 1'b0;
    underrun   = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n) next_state = ARB;
      end
      ARB: begin
        // The load happens even if cs_n rises this cycle; the byte is then dropped.
        sh_load = 1'b1;
        if (found) begin
          req_ready[win] = 1'b1;
          sh_data        = req_bytes[win];
        end else begin
          sh_data  = IDLE_BYTE;
          underrun = 1'b1;
        end
        next_state = cs_n ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (cs_n) begin
          next_state = IDLE;
        end else begin
          sh_shift = 1'b1;
          if (bit_cnt == CW'(DATA_WIDTH - 2)) next_state = ARB;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      abort      <= 1'b0;
    end else begin
      state <= next_state;
      abort <= (state != IDLE) && cs_n;
      if (state == ARB && found) begin
        last_grant <= win;
        grant_id   <= win;
      end
      if (state == ARB) begin
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_miso_tx_arbiter.sv
// Bench for miso_tx_arbiter: byte-period model checked every cycle plus
// hand-computed grant sequences for directed scenarios.
module tb_miso_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        cs_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        sh_load;
  logic [7:0]  sh_data;
  logic        sh_shift;
  logic [1:0]  grant_id;
  logic        busy;
  logic        underrun;
  logic        abort;

  logic [7:0]  d [4];
  assign req_data = {d[3], d[2], d[1], d[0]};

  miso_tx_arbiter #(
    .DATA_WIDTH(8),
    .NUM_REQ   (4),
    .IDLE_BYTE (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .sh_load  (sh_load),
    .sh_data  (sh_data),
    .sh_shift (sh_shift),
    .grant_id (grant_id),
    .busy     (busy),
    .underrun (underrun),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: active flag, position within the 8-cycle byte period, pointer.
  logic m_act;
  int   m_pos;
  int   m_ptr;
  int   m_gid;
  logic m_abort;

  function automatic int pick(input logic [3:0] v, input int p);
    int r;
    int i;
    r = -1;
    for (int k = 1; k <= 4; k++) begin
      i = (p + k) % 4;
      if (r < 0 && v[i[1:0]]) r = i;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act   <= 1'b0;
      m_pos   <= 0;
      m_ptr   <= 3;
      m_gid   <= 0;
      m_abort <= 1'b0;
    end else begin
      m_abort <= m_act && cs_n;
      if (m_act && m_pos == 0 && pick(req_valid, m_ptr) >= 0) begin
        m_ptr <= pick(req_valid, m_ptr);
        m_gid <= pick(req_valid, m_ptr);
      end
      if (!m_act) begin
        if (!cs_n) begin
          m_act <= 1'b1;
          m_pos <= 0;
        end
      end else if (cs_n) begin
        m_act <= 1'b0;
      end else begin
        m_pos <= (m_pos + 1) % 8;
      end
    end
  end

  int         lg_cyc  [$];
  logic [7:0] lg_data [$];
  logic [3:0] lg_rdy  [$];
  logic       lg_und  [$];
  logic [3:0] acc_q;
  int         n_abort;
  logic       autodrop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    int         w;
    logic       e_load;
    logic       e_und;
    logic       e_shift;
    logic [3:0] e_rdy;
    logic [7:0] e_data;
    if (!rst) begin
      acc_q = 4'b0;
    end else begin
      e_load  = m_act && (m_pos == 0);
      w       = pick(req_valid, m_ptr);
      e_rdy   = (e_load && w >= 0) ? 4'(1 << w) : 4'b0;
      e_und   = e_load && (w < 0);
      e_data  = !e_load ? 8'h00 : ((w < 0) ? 8'hFF : d[w[1:0]]);
      e_shift = m_act && (m_pos != 0) && !cs_n;
      chk("busy",      32'(busy),      32'(m_act));
      chk("sh_load",   32'(sh_load),   32'(e_load));
      chk("sh_shift",  32'(sh_shift),  32'(e_shift));
      chk("sh_data",   32'(sh_data),   32'(e_data));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("underrun",  32'(underrun),  32'(e_und));
      chk("abort",     32'(abort),     32'(m_abort));
      chk("grant_id",  32'(grant_id),  32'(m_gid[1:0]));
      if (sh_load) begin
        lg_cyc.push_back(cyc);
        lg_data.push_back(sh_data);
        lg_rdy.push_back(req_ready);
        lg_und.push_back(underrun);
      end
      if (abort) n_abort++;
      acc_q = req_valid & req_ready;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (autodrop) req_valid = req_valid & ~acc_q;
    end
  endtask

  int         c0;
  int         b;
  int         na;
  logic [3:0] s2_rdy  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] s2_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [3:0] s5_rdy  [3] = '{4'b1000, 4'b1000, 4'b0100};
  logic [7:0] s5_data [3] = '{8'h77, 8'h77, 8'h66};

  task automatic stimulus();
    rst = 1'b0; cs_n = 1'b1; req_valid = 4'b0; autodrop = 1'b0;
    acc_q = 4'b0; n_abort = 0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(1);

    // single requester: load at cycle 1, seven shifts, next ARB at cycle 9
    autodrop = 1'b1; d[0] = 8'hA5; req_valid = 4'b0001; cs_n = 1'b0;
    c0 = cyc; b = lg_cyc.size();
    tick(10);
    chk("s1_nload", 32'(lg_cyc.size() - b), 32'd2);
    chk("s1_cyc0",  32'(lg_cyc[b] - c0),    32'd1);
    chk("s1_data0", 32'(lg_data[b]),        32'hA5);
    chk("s1_rdy0",  32'(lg_rdy[b]),         32'b0001);
    chk("s1_cyc1",  32'(lg_cyc[b+1] - c0),  32'd9);
    chk("s1_und1",  32'(lg_und[b+1]),       32'd1);
    chk("s1_gid",   32'(grant_id),          32'd0);
    cs_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);

    // all valid: round-robin 0,1,2,3,0 spaced 8 cycles apart
    autodrop = 1'b0;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    req_valid = 4'b1111; cs_n = 1'b0;
    c0 = cyc; b = lg_cyc.size();
    tick(34);
    chk("s2_nload", 32'(lg_cyc.size() - b), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("s2_cyc",  32'(lg_cyc[b+i] - c0), 32'(1 + 8 * i));
      chk("s2_rdy",  32'(lg_rdy[b+i]),      32'(s2_rdy[i]));
      chk("s2_data", 32'(lg_data[b+i]),     32'(s2_data[i]));
    end

    // nothing valid: idle byte with underrun, grant unchanged
    req_valid = 4'b0;
    b = lg_cyc.size();
    tick(17);
    chk("s3_nload", 32'(lg_cyc.size() - b), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk("s3_data", 32'(lg_data[b+i]), 32'hFF);
      chk("s3_und",  32'(lg_und[b+i]),  32'd1);
      chk("s3_rdy",  32'(lg_rdy[b+i]),  32'd0);
    end
    chk("s3_gid", 32'(grant_id), 32'd0);

    // deselect after three shifts of 3C, then reselect with only req1
    cs_n = 1'b1;
    tick(3);
    na = n_abort;
    autodrop = 1'b1; d[0] = 8'h3C; req_valid = 4'b0001; cs_n = 1'b0;
    c0 = cyc; b = lg_cyc.size();
    tick(5);
    cs_n = 1'b1;
    tick(3);
    chk("s4_nload", 32'(lg_cyc.size() - b), 32'd1);
    chk("s4_cyc",   32'(lg_cyc[b] - c0),    32'd1);
    chk("s4_data",  32'(lg_data[b]),        32'h3C);
    chk("s4_abort", 32'(n_abort - na),      32'd1);
    chk("s4_busy",  32'(busy),              32'd0);
    d[1] = 8'h5A; req_valid = 4'b0010; cs_n = 1'b0;
    b = lg_cyc.size();
    tick(2);
    chk("s4_rdy1",  32'(lg_rdy[b]),  32'b0010);
    chk("s4_data1", 32'(lg_data[b]), 32'h5A);
    chk("s4_gid1",  32'(grant_id),   32'd1);

    // wrap: req3 twice, then req2 beats req3 from index 0
    autodrop = 1'b0; d[3] = 8'h77; d[2] = 8'h66; req_valid = 4'b1000;
    b = lg_cyc.size();
    tick(16);
    req_valid = 4'b1100;
    tick(8);
    chk("s5_nload", 32'(lg_cyc.size() - b), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("s5_rdy",  32'(lg_rdy[b+i]),  32'(s5_rdy[i]));
      chk("s5_data", 32'(lg_data[b+i]), 32'(s5_data[i]));
    end

    // async reset mid-byte clears outputs at once; req0 wins first afterwards
    rst = 1'b0;
    #1;
    chk("s6_outs", 32'({busy, sh_load, sh_shift, underrun, abort, req_ready, grant_id, sh_data}), 32'd0);
    tick(2);
    rst = 1'b1; d[0] = 8'h99; req_valid = 4'b0011;
    b = lg_cyc.size();
    tick(3);
    chk("s6_nload", 32'(lg_cyc.size() - b), 32'd1);
    chk("s6_rdy",   32'(lg_rdy[b]),         32'b0001);
    chk("s6_data",  32'(lg_data[b]),        32'h99);
    cs_n = 1'b1;
    tick(3);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
